jif_resp_tx: RTL and testbench
==============================

// Module: jif_resp_tx
// PURPOSE
//   Response transmitter for the CPU handler's pin interface. Reverse direction of the host
//   command path: takes result words from the core, frames them, and sends them byte-wise on
//   uo_out. Each byte uses a toggle req/ack handshake with the external host.
//   Sits between the core result port and the top-level uo_out / uio_out[0] / uio_in[1] pins.
// PARAMETERS
//   DATA_BYTES     4     payload bytes per frame (>=1); frame = 1 header + DATA_BYTES + 1 checksum
//   FIFO_DEPTH     2     result entries buffered (power of two, >=2)
//   TIMEOUT_CYCLES 1024  cycles waiting for one ack before the frame is aborted (>=4)
// PORTS
//   clk          in   1             system clock
//   rst_n        in   1             asynchronous active-low reset
//   ena          in   1             tile enable; low = no new frame started
//   s_valid      in   1             core result valid
//   s_ready      out  1             buffer can accept (FIFO not full)
//   s_tag        in   4             result tag
//   s_data       in   8*DATA_BYTES  result payload
//   tx_byte      out  8             byte on pins (uo_out)
//   tx_req       out  1             request toggle (uio_out[0])
//   tx_ack       in   1             host ack toggle (uio_in[1]), asynchronous
//   busy         out  1             frame in progress or FIFO non-empty
//   timeout_err  out  1             sticky: a frame was aborted on timeout
//   err_clr      in   1             clears timeout_err
// BEHAVIOUR
//   - Reset values: tx_byte=0, tx_req=0, busy=0, timeout_err=0, FIFO empty, so s_ready=1.
//     State=IDLE. The ack synchronizer resets to 0.
//   - Push on s_valid&&s_ready. s_ready is derived from the registered count only; there is no
//     comb path from a pop. When full, a same-cycle pop does not allow a push.
//   - tx_ack passes through a 2-flop synchronizer to give ack_s. Handshake is complete when
//     ack_s==tx_req.
//   - Frame byte order:
//       byte0 = {4'hA, tag}
//       then data MSB byte first
//       last byte = XOR of all preceding frame bytes
//   - FSM:
//       IDLE:  if FIFO non-empty && ena -> tx_byte<=byte0, idx<=0, SETUP.
//       SETUP: tx_req<=~tx_req, clear timer -> WAIT. tx_byte has been stable for >=1 cycle
//              before the toggle.
//       WAIT:  if ack_s==tx_req:
//                - idx==last: pop FIFO -> IDLE.
//                - otherwise: idx++, tx_byte<=next byte -> SETUP.
//              Else timer++. At timer==TIMEOUT_CYCLES-1: timeout_err<=1, tx_req<=ack_s
//              (withdraw the request), pop (frame dropped) -> IDLE.
//   - Latency: a push at edge T into an empty FIFO with the FSM idle gives tx_byte valid after
//     T+1 and a tx_req toggle at T+2. tx_byte holds until the next load.
//   - Back-to-back frames: IDLE takes 1 cycle between frames. Byte cost = 1 SETUP + ack
//     round trip (>=3 cycles).
//   - ena falling mid-frame: the current frame completes; no new frame starts until ena=1.
//     FIFO pushes are still accepted.
//   - err_clr and a timeout in the same cycle: set wins.
//   - FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 states wide.
//     A simultaneous push and pop leaves count unchanged.
//   - Reset mid-frame: the frame is lost and tx_req returns to 0. The host treats reset as a
//     link reset.
//   - busy = (state!=IDLE) || count!=0.
// TESTING
//   1 Push tag=3, data=32'h12345678; host acks each toggle after 2 cycles.
//     -> bytes A3,12,34,56,78,AB; 6 req toggles; busy falls 1 cycle after the last ack is seen.
//   2 Push 3 results with no ack -> s_ready=0 after 2 pushes; the third push stalls until the
//     first frame completes. No data is lost.
//   3 Host never acks byte 2 -> timeout_err=1 exactly TIMEOUT_CYCLES cycles into WAIT;
//     tx_req==ack_s; the next frame starts with header byte A<tag>.
//   4 ena=0 during byte 3 of frame A, with frame B queued -> frame A finishes; B starts only
//     after ena=1.
//   5 Assert rst_n low in the WAIT state of byte 1 -> all outputs at reset values
//     asynchronously; FIFO empty.
//   6 Pulse err_clr the same cycle a timeout fires -> timeout_err stays 1; a later err_clr
//     alone clears it.

Source files
------------

// File: rtl/jif_resp_tx.sv
// rtl/jif_resp_tx.sv - framed byte-wise response transmitter with toggle req/ack handshake
module jif_resp_tx #(
   parameter int DATA_BYTES     = 4,
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ena_i,
   input  logic                    s_valid_i,
   output logic                    s_ready_o,
   input  logic [3:0]              s_tag_i,
   input  logic [8*DATA_BYTES-1:0] s_data_i,
   output logic [7:0]              tx_byte_o,
   output logic                    tx_req_o,
   input  logic                    tx_ack_i,
   output logic                    busy_o,
   output logic                    timeout_err_o,
   input  logic                    err_clr_i
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int NB = DATA_BYTES + 2;
   localparam int IW = $clog2(NB);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT} state_e;

   logic [3:0]              tag_mem_q  [FIFO_DEPTH];
   logic [8*DATA_BYTES-1:0] data_mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]           count_q;
   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [7:0]              tx_byte_q, tx_byte_d;
   logic                    tx_req_q, tx_req_d;
   logic                    err_q, err_d;
   logic                    ack_meta_q, ack_s_q;
   logic                    push, pop, tmo;
   logic [7:0]              frame_bytes [NB];

   // s_ready depends only on the registered count, so a pop never opens a full FIFO in the same cycle
   assign s_ready_o     = (count_q != FULL_CNT);
   assign push          = s_valid_i && s_ready_o;
   assign tx_byte_o     = tx_byte_q;
   assign tx_req_o      = tx_req_q;
   assign timeout_err_o = err_q;
   assign busy_o        = (state_q != ST_IDLE) || (count_q != '0);

   // Result storage, written on an accepted push; contents need no reset
   always_ff @(posedge clk_i) begin
      if (push) begin
         tag_mem_q[wr_ptr_q]  <= s_tag_i;
         data_mem_q[wr_ptr_q] <= s_data_i;
      end
   end

   // FIFO pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (!push && pop) count_q <= count_q - CW'(1);
      end
   end

   // Frame image of the FIFO head: header, payload MSB byte first, XOR checksum of all before it
   always_comb begin
      logic [7:0] chk;
      frame_bytes[0] = {4'hA, tag_mem_q[rd_ptr_q]};
      chk = frame_bytes[0];
      for (int i = 1; i <= DATA_BYTES; i++) begin
         frame_bytes[i] = data_mem_q[rd_ptr_q][8*(DATA_BYTES-i) +: 8];
         chk = chk ^ frame_bytes[i];
      end
      frame_bytes[NB-1] = chk;
   end

   // State, handshake registers and the two-flop ack synchronizer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         timer_q    <= '0;
         tx_byte_q  <= '0;
         tx_req_q   <= 1'b0;
         err_q      <= 1'b0;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         tx_byte_q  <= tx_byte_d;
         tx_req_q   <= tx_req_d;
         err_q      <= err_d;
         ack_meta_q <= tx_ack_i;
         ack_s_q    <= ack_meta_q;
      end
   end

   // Next-state logic: load byte, toggle request, wait for matching ack or time out
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      timer_d   = timer_q;
      tx_byte_d = tx_byte_q;
      tx_req_d  = tx_req_q;
      pop       = 1'b0;
      tmo       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((count_q != '0) && ena_i) begin
               tx_byte_d = frame_bytes[0];
               idx_d     = '0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            tx_req_d = ~tx_req_q;
            timer_d  = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (ack_s_q == tx_req_q) begin
               if (idx_q == LAST_IDX) begin
                  pop     = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d     = idx_q + IW'(1);
                  tx_byte_d = frame_bytes[idx_q + IW'(1)];
                  state_d   = ST_SETUP;
               end
            end else if (timer_q == TMO_LAST) begin
               // Withdraw the outstanding request and drop the frame
               tmo      = 1'b1;
               tx_req_d = ack_s_q;
               pop      = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A timeout in the same cycle as a clear leaves the error set
      err_d = tmo ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
   end
endmodule

// File: tb/tb_jif_resp_tx.sv
// tb/tb_jif_resp_tx.sv - scoreboard bench for jif_resp_tx
module tb_jif_resp_tx;
   localparam int TMO = 32;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        ena_i = 1'b1;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o;
   logic [3:0]  s_tag_i = '0;
   logic [31:0] s_data_i = '0;
   logic [7:0]  tx_byte_o;
   logic        tx_req_o;
   logic        tx_ack_i = 1'b0;
   logic        busy_o;
   logic        timeout_err_o;
   logic        err_clr_i = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int host_limit = 1000000;
   int host_dly = 2;
   int host_acks = 0;
   int ack_wait = 0;
   int req_count = 0;
   int last_req_cyc = 0;
   int last_ack_cyc = 0;
   logic mon_prev_req = 1'b0;
   logic [7:0] exp_q [$];

   jif_resp_tx #(.DATA_BYTES(4), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .s_valid_i(s_valid_i),
      .s_ready_o(s_ready_o), .s_tag_i(s_tag_i), .s_data_i(s_data_i),
      .tx_byte_o(tx_byte_o), .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i),
      .busy_o(busy_o), .timeout_err_o(timeout_err_o), .err_clr_i(err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc++;

   function automatic logic [7:0] model_byte(input logic [3:0] tag, input logic [31:0] d, input int k);
      logic [7:0] b [6];
      b[0] = {4'hA, tag};
      b[1] = d[31:24];
      b[2] = d[23:16];
      b[3] = d[15:8];
      b[4] = d[7:0];
      b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
      return b[k];
   endfunction

   // Host: answers a pending request after host_dly cycles, up to host_limit acks
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         tx_ack_i = 1'b0;
         ack_wait = 0;
      end else if (tx_req_o !== tx_ack_i && host_acks < host_limit) begin
         if (ack_wait >= host_dly) begin
            tx_ack_i = ~tx_ack_i;
            ack_wait = 0;
            host_acks++;
            last_ack_cyc = cyc;
         end else begin
            ack_wait++;
         end
      end else begin
         ack_wait = 0;
      end
   end

   // Monitor: every new request toggle presents one frame byte, compared against the scoreboard
   always @(negedge clk_i) begin
      if (rst_ni && tx_req_o !== mon_prev_req && tx_req_o !== tx_ack_i) begin
         req_count++;
         last_req_cyc = cyc;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_byte: got %h, required none (scoreboard empty)", tx_byte_o);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (tx_byte_o !== e) begin
               n_fail++;
               $display("FAIL frame_byte: got %h, required %h", tx_byte_o, e);
            end
         end
      end
      mon_prev_req = tx_req_o;
   end

   task automatic push_result(input logic [3:0] tag, input logic [31:0] d);
      int t = 0;
      s_valid_i = 1'b1;
      s_tag_i = tag;
      s_data_i = d;
      while (!s_ready_o && t < 2000) begin
         @(negedge clk_i);
         t++;
      end
      n_checks++;
      if (!s_ready_o) begin
         n_fail++;
         $display("FAIL push_accept: s_ready stayed %b, required 1", s_ready_o);
      end
      @(posedge clk_i);
      #1 s_valid_i = 1'b0;
      for (int k = 0; k < 6; k++) exp_q.push_back(model_byte(tag, d, k));
      @(negedge clk_i);
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy_o !== 1'b0 && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle: busy %b, required 0", name, busy_o);
      end
   endtask

   task automatic wait_req(input int n);
      int t = 0;
      while (req_count < n && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      n_checks++;
      if (req_count < n) begin
         n_fail++;
         $display("FAIL wait_req: count %0d, required %0d", req_count, n);
      end
   endtask

   task automatic check_empty_sb(input string name, input int remain);
      n_checks++;
      if (exp_q.size() != remain) begin
         n_fail++;
         $display("FAIL %s_scoreboard: %0d bytes left, required %0d", name, exp_q.size(), remain);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      n_checks++;
      if (tx_byte_o !== 8'h00 || tx_req_o !== 1'b0 || busy_o !== 1'b0 ||
          timeout_err_o !== 1'b0 || s_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_values: byte=%h req=%b busy=%b err=%b rdy=%b, required 00 0 0 0 1",
                  tx_byte_o, tx_req_o, busy_o, timeout_err_o, s_ready_o);
      end
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      int base = req_count;
      host_limit = 1000000;
      push_result(4'h3, 32'h12345678);
      n_checks++;
      if (tx_req_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_after_push: req=%b busy=%b, required 0 1", tx_req_o, busy_o);
      end
      @(negedge clk_i);
      n_checks++;
      if (tx_byte_o !== 8'hA3 || tx_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_byte0_setup: byte=%h req=%b, required a3 0", tx_byte_o, tx_req_o);
      end
      @(negedge clk_i);
      n_checks++;
      if (tx_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_first_toggle: req=%b, required 1", tx_req_o);
      end
      wait_idle("basic");
      n_checks++;
      if (cyc - last_ack_cyc != 3) begin
         n_fail++;
         $display("FAIL basic_busy_fall: %0d cycles after ack, required 3", cyc - last_ack_cyc);
      end
      n_checks++;
      if (req_count - base != 6) begin
         n_fail++;
         $display("FAIL basic_toggles: %0d, required 6", req_count - base);
      end
      n_checks++;
      if (tx_byte_o !== 8'hAB) begin
         n_fail++;
         $display("FAIL basic_hold_checksum: byte=%h, required ab", tx_byte_o);
      end
      check_empty_sb("basic", 0);
   endtask

   task automatic test_backpressure();
      int base = req_count;
      host_limit = host_acks;
      push_result(4'h1, 32'hFFFF0000);
      push_result(4'h2, 32'h00000000);
      n_checks++;
      if (s_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full: s_ready=%b, required 0", s_ready_o);
      end
      fork
         push_result(4'h7, 32'hDEADBEEF);
         begin
            repeat (5) @(negedge clk_i);
            n_checks++;
            if (s_ready_o !== 1'b0 || s_valid_i !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_stall: s_ready=%b s_valid=%b, required 0 1", s_ready_o, s_valid_i);
            end
            host_limit = 1000000;
         end
      join
      wait_idle("bp");
      n_checks++;
      if (req_count - base != 18) begin
         n_fail++;
         $display("FAIL bp_toggles: %0d, required 18", req_count - base);
      end
      check_empty_sb("bp", 0);
   endtask

   task automatic test_ena();
      int base = req_count;
      host_limit = 1000000;
      push_result(4'hC, 32'h0F1E2D3C);
      wait_req(base + 3);
      ena_i = 1'b0;
      push_result(4'h4, 32'hA5A55A5A);
      wait_req(base + 6);
      repeat (20) @(negedge clk_i);
      n_checks++;
      if (req_count - base != 6 || busy_o !== 1'b1 || s_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ena_hold: toggles=%0d busy=%b rdy=%b, required 6 1 1",
                  req_count - base, busy_o, s_ready_o);
      end
      n_checks++;
      if (tx_byte_o !== model_byte(4'hC, 32'h0F1E2D3C, 5)) begin
         n_fail++;
         $display("FAIL ena_byte_hold: byte=%h, required %h", tx_byte_o,
                  model_byte(4'hC, 32'h0F1E2D3C, 5));
      end
      ena_i = 1'b1;
      wait_idle("ena");
      n_checks++;
      if (req_count - base != 12) begin
         n_fail++;
         $display("FAIL ena_toggles: %0d, required 12", req_count - base);
      end
      check_empty_sb("ena", 0);
   endtask

   task automatic test_timeout();
      int w;
      int t = 0;
      host_limit = host_acks + 1;
      push_result(4'h5, 32'h89ABCDEF);
      wait_req(req_count + 2);
      w = last_req_cyc;
      while (timeout_err_o !== 1'b1 && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      n_checks++;
      if (timeout_err_o !== 1'b1 || cyc - w != TMO) begin
         n_fail++;
         $display("FAIL timeout_time: err=%b after %0d cycles, required 1 after %0d",
                  timeout_err_o, cyc - w, TMO);
      end
      n_checks++;
      if (tx_req_o !== tx_ack_i) begin
         n_fail++;
         $display("FAIL timeout_withdraw: req=%b ack=%b, required equal", tx_req_o, tx_ack_i);
      end
      wait_idle("timeout");
      check_empty_sb("timeout", 4);
      host_limit = 1000000;
      push_result(4'h9, 32'h31415926);
      wait_idle("timeout_next");
      check_empty_sb("timeout_next", 0);
   endtask

   task automatic test_err_clr();
      int w;
      int t = 0;
      err_clr_i = 1'b1;
      @(posedge clk_i);
      #1 err_clr_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr_alone: err=%b, required 0", timeout_err_o);
      end
      host_limit = host_acks;
      push_result(4'hE, 32'h76543210);
      wait_req(req_count + 1);
      w = last_req_cyc;
      while (cyc != w + TMO - 1 && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      n_checks++;
      if (timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_early: err=%b one cycle before timeout, required 0", timeout_err_o);
      end
      err_clr_i = 1'b1;
      @(posedge clk_i);
      #1 err_clr_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (timeout_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set_wins: err=%b, required 1", timeout_err_o);
      end
      err_clr_i = 1'b1;
      @(posedge clk_i);
      #1 err_clr_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (timeout_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clr_later: err=%b, required 0", timeout_err_o);
      end
      wait_idle("err");
      check_empty_sb("err", 5);
      host_limit = 1000000;
   endtask

   task automatic test_reset_mid();
      host_limit = host_acks;
      push_result(4'h6, 32'h13579BDF);
      wait_req(req_count + 1);
      repeat (3) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (tx_byte_o !== 8'h00 || tx_req_o !== 1'b0 || busy_o !== 1'b0 ||
          timeout_err_o !== 1'b0 || s_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid: byte=%h req=%b busy=%b err=%b rdy=%b, required 00 0 0 0 1",
                  tx_byte_o, tx_req_o, busy_o, timeout_err_o, s_ready_o);
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      check_empty_sb("reset_mid", 5);
      @(negedge clk_i);
      host_limit = 1000000;
      push_result(4'hB, 32'h02468ACE);
      wait_idle("reset_recover");
      check_empty_sb("reset_recover", 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_ena();
      test_timeout();
      test_err_clr();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
